// File: rtl/mips_core_pkg.sv
// Shared MIPS core types: branch outcome, branch condition codes and resolver FSM states.
package mips_core_pkg;

  typedef enum logic {
    NOT_TAKEN = 1'b0,
    TAKEN     = 1'b1
  } branch_outcome_e;

  typedef enum logic [2:0] {
    BEQ  = 3'd0,
    BNE  = 3'd1,
    BLEZ = 3'd2,
    BGTZ = 3'd3,
    BLTZ = 3'd4,
    BGEZ = 3'd5
  } branch_cond_e;

  typedef enum logic {
    RUN    = 1'b0,
    SQUASH = 1'b1
  } resolver_state_e;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational evaluation of a conditional branch outcome from its register operands.
module branch_cond_eval
  import mips_core_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2:0]            i_cond,
  input  logic [DATA_WIDTH-1:0] i_op_a,
  input  logic [DATA_WIDTH-1:0] i_op_b,
  output branch_outcome_e       o_outcome
);

  logic a_neg;
  logic a_zero;
  logic taken;

  // Zero compares are signed: sign bit plus an all-zero test covers every case.
  assign a_neg  = i_op_a[DATA_WIDTH-1];
  assign a_zero = (i_op_a == '0);

  always_comb begin
    taken = 1'b0;
    case (i_cond)
      BEQ:     taken = (i_op_a == i_op_b);
      BNE:     taken = (i_op_a != i_op_b);
      BLEZ:    taken = a_neg | a_zero;
      BGTZ:    taken = ~a_neg & ~a_zero;
      BLTZ:    taken = a_neg;
      BGEZ:    taken = ~a_neg;
      default: taken = 1'b0;
    endcase
  end

  assign o_outcome = taken ? TAKEN : NOT_TAKEN;

endmodule

// File: rtl/branch_resolver.sv
// Execute-stage branch resolution: predictor feedback, misprediction redirect,
// saturating statistics and a post-redirect squash window.
//   state  | meaning
//   RUN    | branches accepted and resolved
//   SQUASH | wrong-path window after a redirect; inputs ignored
module branch_resolver
  import mips_core_pkg::*;
#(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int CNT_WIDTH     = 32,
  parameter int SQUASH_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_stall,
  input  logic                  i_flush,
  input  logic                  i_valid,
  input  logic                  i_is_jump,
  input  logic [2:0]            i_cond,
  input  logic [ADDR_WIDTH-1:0] i_pc,
  input  logic [ADDR_WIDTH-1:0] i_recovery_target,
  input  logic                  i_prediction,
  input  logic [DATA_WIDTH-1:0] i_op_a,
  input  logic [DATA_WIDTH-1:0] i_op_b,
  output logic                  o_fb_valid,
  output logic [ADDR_WIDTH-1:0] o_fb_pc,
  output logic                  o_fb_prediction,
  output logic                  o_fb_outcome,
  output logic                  o_redirect_valid,
  output logic [ADDR_WIDTH-1:0] o_redirect_pc,
  output logic [CNT_WIDTH-1:0]  o_branch_count,
  output logic [CNT_WIDTH-1:0]  o_mispredict_count
);

  localparam int SW = $clog2(SQUASH_CYCLES + 1);

  resolver_state_e state, state_nxt;
  logic [SW-1:0]   squash_cnt, squash_cnt_nxt;
  branch_outcome_e outcome;
  logic            accept;
  logic            mispredict;

  branch_cond_eval #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_eval (
    .i_cond   (i_cond),
    .i_op_a   (i_op_a),
    .i_op_b   (i_op_b),
    .o_outcome(outcome)
  );

  assign accept     = i_valid & ~i_is_jump & ~i_stall & ~i_flush & (state == RUN);
  assign mispredict = accept & (outcome != i_prediction);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RUN;
      squash_cnt <= '0;
    end else begin
      state      <= state_nxt;
      squash_cnt <= squash_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    squash_cnt_nxt = squash_cnt;
    case (state)
      RUN: begin
        if (mispredict) begin
          state_nxt      = SQUASH;
          squash_cnt_nxt = SW'(SQUASH_CYCLES - 1);
        end
      end
      SQUASH: begin
        if (squash_cnt == '0) state_nxt = RUN;
        else                  squash_cnt_nxt = squash_cnt - 1'b1;
      end
      default: state_nxt = RUN;
    endcase
  end

  // Valid flags pulse for one cycle; data fields hold until the next event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_fb_valid       <= 1'b0;
      o_fb_pc          <= '0;
      o_fb_prediction  <= 1'b0;
      o_fb_outcome     <= 1'b0;
      o_redirect_valid <= 1'b0;
      o_redirect_pc    <= '0;
    end else begin
      o_fb_valid       <= accept;
      o_redirect_valid <= mispredict;
      if (accept) begin
        o_fb_pc         <= i_pc;
        o_fb_prediction <= i_prediction;
        o_fb_outcome    <= (outcome == TAKEN);
      end
      if (mispredict) o_redirect_pc <= i_recovery_target;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_branch_count     <= '0;
      o_mispredict_count <= '0;
    end else begin
      if (accept && !(&o_branch_count))
        o_branch_count <= o_branch_count + CNT_WIDTH'(1);
      if (mispredict && !(&o_mispredict_count))
        o_mispredict_count <= o_mispredict_count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_branch_resolver.sv
// Directed table-driven bench for branch_resolver with hand-written squash, saturation and reset sequences.
module tb_branch_resolver;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int CW = 4;
  localparam int SQ = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_stall, i_flush, i_valid, i_is_jump, i_prediction;
  logic [2:0]    i_cond;
  logic [AW-1:0] i_pc, i_recovery_target;
  logic [DW-1:0] i_op_a, i_op_b;
  logic          o_fb_valid, o_fb_prediction, o_fb_outcome, o_redirect_valid;
  logic [AW-1:0] o_fb_pc, o_redirect_pc;
  logic [CW-1:0] o_branch_count, o_mispredict_count;

  branch_resolver #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW), .SQUASH_CYCLES(SQ)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_stall(i_stall), .i_flush(i_flush),
    .i_valid(i_valid), .i_is_jump(i_is_jump), .i_cond(i_cond), .i_pc(i_pc),
    .i_recovery_target(i_recovery_target), .i_prediction(i_prediction),
    .i_op_a(i_op_a), .i_op_b(i_op_b),
    .o_fb_valid(o_fb_valid), .o_fb_pc(o_fb_pc), .o_fb_prediction(o_fb_prediction),
    .o_fb_outcome(o_fb_outcome), .o_redirect_valid(o_redirect_valid),
    .o_redirect_pc(o_redirect_pc), .o_branch_count(o_branch_count),
    .o_mispredict_count(o_mispredict_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid, jump, stall, flush;
    logic [2:0]  cond;
    logic [31:0] a, b;
    logic        pred;
    logic [31:0] pc, rec;
    logic        exp_fb, exp_out, exp_redir;
  } vec_t;

  vec_t vecs[18];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   exp_br  = 0;
  int   exp_mp  = 0;
  logic [31:0] last_fb_pc  = '0;
  logic [31:0] last_red_pc = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    i_valid = 1'b0; i_is_jump = 1'b0; i_stall = 1'b0; i_flush = 1'b0;
    i_cond = 3'd0; i_op_a = '0; i_op_b = '0; i_prediction = 1'b0;
    i_pc = '0; i_recovery_target = '0;
  endtask

  task automatic drive(input vec_t v);
    i_valid = v.valid; i_is_jump = v.jump; i_stall = v.stall; i_flush = v.flush;
    i_cond = v.cond; i_op_a = v.a; i_op_b = v.b; i_prediction = v.pred;
    i_pc = v.pc; i_recovery_target = v.rec;
  endtask

  function automatic int sat(input int x);
    return (x > 15) ? 15 : x;
  endfunction

  task automatic branch(input logic [2:0] cond, input logic [31:0] a, input logic [31:0] b,
                        input logic pred, input logic [31:0] pc, input logic [31:0] rec);
    idle();
    i_valid = 1'b1; i_cond = cond; i_op_a = a; i_op_b = b;
    i_prediction = pred; i_pc = pc; i_recovery_target = rec;
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_branch_count"}, 32'(o_branch_count), 32'(exp_br));
    check({tag, "_mispredict_count"}, 32'(o_mispredict_count), 32'(exp_mp));
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    exp_br = 0; exp_mp = 0; last_fb_pc = '0; last_red_pc = '0;
  endtask

  initial begin
    //           valid jump stall flush cond   a             b      pred  pc        rec       fb  out redir
    vecs[0]  = '{1'b1,1'b0,1'b0,1'b0, 3'd0, 32'd5,        32'd5, 1'b0, 32'h100, 32'h140, 1'b1,1'b1,1'b1};
    vecs[1]  = '{1'b1,1'b0,1'b0,1'b0, 3'd3, 32'hFFFFFFFF, 32'd0, 1'b0, 32'h104, 32'h200, 1'b1,1'b0,1'b0};
    vecs[2]  = '{1'b1,1'b0,1'b0,1'b0, 3'd1, 32'd3,        32'd4, 1'b1, 32'h108, 32'h10C, 1'b1,1'b1,1'b0};
    vecs[3]  = '{1'b1,1'b0,1'b0,1'b0, 3'd1, 32'd7,        32'd7, 1'b1, 32'h110, 32'h114, 1'b1,1'b0,1'b1};
    vecs[4]  = '{1'b1,1'b0,1'b0,1'b0, 3'd2, 32'd0,        32'd9, 1'b1, 32'h118, 32'h11C, 1'b1,1'b1,1'b0};
    vecs[5]  = '{1'b1,1'b0,1'b0,1'b0, 3'd2, 32'd1,        32'd0, 1'b0, 32'h120, 32'h124, 1'b1,1'b0,1'b0};
    vecs[6]  = '{1'b1,1'b0,1'b0,1'b0, 3'd2, 32'h80000000, 32'd0, 1'b1, 32'h128, 32'h12C, 1'b1,1'b1,1'b0};
    vecs[7]  = '{1'b1,1'b0,1'b0,1'b0, 3'd3, 32'h7FFFFFFF, 32'd0, 1'b1, 32'h130, 32'h134, 1'b1,1'b1,1'b0};
    vecs[8]  = '{1'b1,1'b0,1'b0,1'b0, 3'd4, 32'hFFFFFFFF, 32'd0, 1'b1, 32'h138, 32'h13C, 1'b1,1'b1,1'b0};
    vecs[9]  = '{1'b1,1'b0,1'b0,1'b0, 3'd4, 32'd0,        32'd0, 1'b1, 32'h140, 32'h400, 1'b1,1'b0,1'b1};
    vecs[10] = '{1'b1,1'b0,1'b0,1'b0, 3'd5, 32'd0,        32'd0, 1'b1, 32'h148, 32'h14C, 1'b1,1'b1,1'b0};
    vecs[11] = '{1'b1,1'b0,1'b0,1'b0, 3'd5, 32'h80000000, 32'd0, 1'b0, 32'h150, 32'h154, 1'b1,1'b0,1'b0};
    vecs[12] = '{1'b1,1'b0,1'b0,1'b0, 3'd6, 32'd0,        32'd0, 1'b1, 32'h158, 32'h500, 1'b1,1'b0,1'b1};
    vecs[13] = '{1'b1,1'b0,1'b0,1'b0, 3'd7, 32'd1,        32'd1, 1'b0, 32'h160, 32'h164, 1'b1,1'b0,1'b0};
    vecs[14] = '{1'b1,1'b0,1'b1,1'b0, 3'd0, 32'd5,        32'd5, 1'b0, 32'h168, 32'h600, 1'b0,1'b0,1'b0};
    vecs[15] = '{1'b1,1'b0,1'b0,1'b1, 3'd0, 32'd5,        32'd5, 1'b0, 32'h170, 32'h700, 1'b0,1'b0,1'b0};
    vecs[16] = '{1'b1,1'b1,1'b0,1'b0, 3'd0, 32'd5,        32'd5, 1'b0, 32'h178, 32'h800, 1'b0,1'b0,1'b0};
    vecs[17] = '{1'b0,1'b0,1'b0,1'b0, 3'd0, 32'd5,        32'd5, 1'b0, 32'h180, 32'h900, 1'b0,1'b0,1'b0};

    idle();
    rst_n = 1'b0;
    #12;
    check("reset_fb_valid", 32'(o_fb_valid), 32'd0);
    check("reset_redirect_valid", 32'(o_redirect_valid), 32'd0);
    check("reset_fb_pc", o_fb_pc, 32'd0);
    check("reset_redirect_pc", o_redirect_pc, 32'd0);
    check_counts("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Table: each vector is followed by idle cycles that clear any squash window.
    for (int i = 0; i < 18; i++) begin
      drive(vecs[i]);
      tick();
      check($sformatf("v%0d_fb_valid", i), 32'(o_fb_valid), 32'(vecs[i].exp_fb));
      check($sformatf("v%0d_redirect_valid", i), 32'(o_redirect_valid), 32'(vecs[i].exp_redir));
      if (vecs[i].exp_fb) begin
        last_fb_pc = vecs[i].pc;
        check($sformatf("v%0d_outcome", i), 32'(o_fb_outcome), 32'(vecs[i].exp_out));
        check($sformatf("v%0d_prediction", i), 32'(o_fb_prediction), 32'(vecs[i].pred));
        exp_br = sat(exp_br + 1);
      end
      if (vecs[i].exp_redir) begin
        last_red_pc = vecs[i].rec;
        exp_mp = sat(exp_mp + 1);
      end
      check($sformatf("v%0d_fb_pc", i), o_fb_pc, last_fb_pc);
      check($sformatf("v%0d_redirect_pc", i), o_redirect_pc, last_red_pc);
      check_counts($sformatf("v%0d", i));
      idle();
      tick();
      check($sformatf("v%0d_fb_fall", i), 32'(o_fb_valid), 32'd0);
      check($sformatf("v%0d_redirect_fall", i), 32'(o_redirect_valid), 32'd0);
      tick();
    end

    // Squash window: mispredict in N, branches in N+1 and N+2 ignored, N+3 accepted.
    do_reset();
    branch(3'd0, 32'd5, 32'd5, 1'b0, 32'h100, 32'h140);
    tick();
    exp_br = 1; exp_mp = 1;
    check("sq_redirect_valid", 32'(o_redirect_valid), 32'd1);
    check("sq_redirect_pc", o_redirect_pc, 32'h140);
    for (int k = 1; k <= 2; k++) begin
      branch(3'd0, 32'd1, 32'd1, 1'b1, 32'h200 + 32'(k), 32'h300);
      tick();
      check($sformatf("sq_n%0d_fb_valid", k), 32'(o_fb_valid), 32'd0);
      check($sformatf("sq_n%0d_redirect_valid", k), 32'(o_redirect_valid), 32'd0);
      check_counts($sformatf("sq_n%0d", k));
    end
    branch(3'd0, 32'd1, 32'd1, 1'b1, 32'h210, 32'h300);
    tick();
    exp_br = 2;
    check("sq_n3_fb_valid", 32'(o_fb_valid), 32'd1);
    check("sq_n3_fb_pc", o_fb_pc, 32'h210);
    check_counts("sq_n3");
    // Back-to-back correct predictions in RUN give consecutive pulses.
    branch(3'd1, 32'd1, 32'd2, 1'b1, 32'h214, 32'h300);
    tick();
    exp_br = 3;
    check("b2b_fb_valid", 32'(o_fb_valid), 32'd1);
    check("b2b_fb_pc", o_fb_pc, 32'h214);
    check_counts("b2b");
    // Stall does not extend a pulse.
    i_stall = 1'b1;
    tick();
    check("stall_fb_fall", 32'(o_fb_valid), 32'd0);
    idle();

    // Saturation: 20 spaced mispredicts leave both 4-bit counters at 15.
    do_reset();
    for (int k = 0; k < 20; k++) begin
      branch(3'd0, 32'd9, 32'd9, 1'b0, 32'h1000 + 32'(4*k), 32'h2000);
      tick();
      idle();
      tick();
      tick();
    end
    exp_br = 15; exp_mp = 15;
    check_counts("sat");

    // Asynchronous reset in the middle of a squash window.
    do_reset();
    branch(3'd0, 32'd5, 32'd5, 1'b0, 32'h100, 32'h140);
    tick();
    check("ars_pre_redirect", 32'(o_redirect_valid), 32'd1);
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    check("ars_fb_valid", 32'(o_fb_valid), 32'd0);
    check("ars_redirect_valid", 32'(o_redirect_valid), 32'd0);
    check("ars_fb_pc", o_fb_pc, 32'd0);
    check("ars_redirect_pc", o_redirect_pc, 32'd0);
    check("ars_fb_outcome", 32'(o_fb_outcome), 32'd0);
    check("ars_fb_prediction", 32'(o_fb_prediction), 32'd0);
    exp_br = 0; exp_mp = 0;
    check_counts("ars");
    rst_n = 1'b1;
    branch(3'd1, 32'd1, 32'd2, 1'b1, 32'h3000, 32'h3004);
    tick();
    exp_br = 1;
    check("ars_first_fb_valid", 32'(o_fb_valid), 32'd1);
    check("ars_first_fb_pc", o_fb_pc, 32'h3000);
    check_counts("ars_first");
    idle();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_resolver.md
# branch_resolver

Execute-stage branch resolution unit, directly downstream of the branch controller. It receives each conditional branch after decode, together with the prediction and recovery target that decode attached to it. It evaluates the real outcome from the register operands and drives two registered outputs: the one-cycle feedback pulse consumed by the predictor, and the misprediction redirect consumed by fetch and hazard control. It also holds saturating branch and misprediction statistics counters and a squash window that ignores wrong-path branches after a redirect.

## Interface
Parameters:
- ADDR_WIDTH, 32, PC/target width
- DATA_WIDTH, 32, operand width
- CNT_WIDTH, 32, statistics counter width
- SQUASH_CYCLES, 2, cycles of ignored input after a redirect (minimum 1)

Ports:
- clk  in  1  clock. One clock; all state on its rising edge.
- rst_n  in  1  reset. Asynchronous, active-low.
- i_stall  in  1  EX stalled; input not accepted
- i_flush  in  1  EX contents squashed by hazard control; input not accepted
- i_valid  in  1  branch/jump present in EX
- i_is_jump  in  1  unconditional jump; never resolved here
- i_cond  in  3  BranchCond code (BEQ, BNE, BLEZ, BGTZ, BLTZ, BGEZ)
- i_pc  in  ADDR_WIDTH  branch PC
- i_recovery_target  in  ADDR_WIDTH  other-path PC supplied by decode
- i_prediction  in  1  BranchOutcome predicted at decode
- i_op_a, i_op_b  in  DATA_WIDTH  rs/rt values
- o_fb_valid  out  1  feedback pulse
- o_fb_pc  out  ADDR_WIDTH  PC of resolved branch
- o_fb_prediction  out  1  prediction echoed back
- o_fb_outcome  out  1  actual outcome
- o_redirect_valid  out  1  misprediction redirect pulse
- o_redirect_pc  out  ADDR_WIDTH  correct PC (= i_recovery_target of the branch)
- o_branch_count  out  CNT_WIDTH  resolved conditional branches
- o_mispredict_count  out  CNT_WIDTH  mispredictions

## Operation
- accept = i_valid & ~i_is_jump & ~i_stall & ~i_flush & (state == RUN).
- Outcome evaluation (signed for the zero compares):
  - BEQ: a==b. BNE: a!=b.
  - BLEZ: a<=0. BGTZ: a>0. BLTZ: a<0. BGEZ: a>=0.
  - Undefined code gives NOT_TAKEN.
- mispredict = accept & (outcome != i_prediction).
- States:
  - RUN: normal operation. On a mispredict, go to SQUASH and load squash_cnt = SQUASH_CYCLES-1.
  - SQUASH: decrement squash_cnt each cycle; return to RUN when squash_cnt == 0.
  - In SQUASH, i_valid is ignored: no feedback, no counting.
- Counters:
  - o_branch_count += 1 on each accept.
  - o_mispredict_count += 1 on each mispredict.
  - Both saturate at all-ones and never wrap.
- Jumps, stalled or flushed inputs, and inputs arriving in SQUASH produce no output and no count change.

## Timing
- Latency: accept in cycle N, then o_fb_* and o_redirect_* are valid in cycle N+1, as one-cycle pulses.
- Pulse behaviour:
  - Valid flags deassert in N+2 unless another accept occurred in N+1.
  - i_stall does not extend a pulse.
  - Data outputs hold their last value while the valid flag is low.
- Counters update at the same edge that raises o_fb_valid.
- Back-to-back accepts while in RUN give consecutive pulses. A mispredict in N blocks acceptance in N+1 .. N+SQUASH_CYCLES.
- Simultaneous i_flush and i_valid: flush wins.
- Reset (asynchronous, any cycle, including mid-SQUASH) forces:
  - state = RUN, squash_cnt = 0
  - all valid flags = 0, all data outputs = 0
  - both counters = 0
- First accept is possible on the first rising edge after rst_n deasserts.

## Structure
- Add to mips_core_pkg:
  - BranchCond enum (3 bits)
  - ResolverState enum (RUN, SQUASH)
- Reuse the existing BranchOutcome.
- One combinational sub-module, branch_cond_eval (i_cond, i_op_a, i_op_b → outcome). The top module holds the FSM, output registers and counters.

## Test plan
- BEQ, a=5, b=5, prediction NOT_TAKEN, pc 0x100, recovery 0x140:
  - next cycle: o_fb_valid=1, outcome TAKEN, o_redirect_valid=1, o_redirect_pc=0x140
  - o_mispredict_count=1
- BGTZ, a=0xFFFFFFFF (−1), prediction NOT_TAKEN:
  - next cycle: o_fb_valid=1, outcome NOT_TAKEN, no redirect
  - o_branch_count=1, o_mispredict_count=0
- Mispredict at cycle N, then valid branches in N+1 and N+2 (SQUASH_CYCLES=2):
  - no feedback for either, counters unchanged
  - branch in N+3 is accepted
- i_valid with i_stall=1, then with i_flush=1, then with i_is_jump=1: no pulses and no counter change in any case.
- Preload counters near saturation (CNT_WIDTH=4): 20 mispredicting branches spaced outside the squash window leave both counters at 15.
- Assert rst_n=0 mid-SQUASH between clock edges:
  - all outputs read 0 immediately, before the next edge
  - after release, a branch is accepted on the first edge
